// File: rtl/pixel_fetch_cntrl_if.sv
// Memory-side bus of the pixel fetch controller.
// master: fetch controller (drives address/strobes); slave: memory model.
interface pixel_fetch_cntrl_if #(
   parameter int unsigned MEM_ADDR_WIDTH = 24,
   parameter int unsigned DATA_WIDTH     = 16
);
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]     mem_data_in;
   logic                      mem_r_en;
   logic                      mem_w_en;
   logic [DATA_WIDTH-1:0]     mem_data_out;
   logic                      mem_rdy;
   logic                      mem_cplt;

   modport master (
      output mem_addr,
      output mem_data_in,
      output mem_r_en,
      output mem_w_en,
      input  mem_data_out,
      input  mem_rdy,
      input  mem_cplt
   );

   modport slave (
      input  mem_addr,
      input  mem_data_in,
      input  mem_r_en,
      input  mem_w_en,
      output mem_data_out,
      output mem_rdy,
      output mem_cplt
   );
endinterface

// File: rtl/pixel_fetch_cntrl.sv
// Pixel fetch controller: prefetches framebuffer words into a small FIFO
// (one read in flight at most) and serializes them into RGB565 pixels.
module pixel_fetch_cntrl #(
   parameter int unsigned MEM_ADDR_WIDTH = 24,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned BPP            = 1,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned FB_BASE        = 46336,
   parameter int unsigned FB_WORDS       = 19200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                frame_start,
   input  logic                pixel_req,
   output logic [4:0]          pixel_red,
   output logic [5:0]          pixel_green,
   output logic [4:0]          pixel_blue,
   output logic                pixel_valid,
   output logic                underflow,
   pixel_fetch_cntrl_if.master mem
);

   localparam int unsigned PIX_PER_WORD = 16 / BPP;
   localparam int unsigned IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W        = PTR_W + 1;

   localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(PIX_PER_WORD - 1);
   localparam logic [CNT_W-1:0]          FIFO_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_BASE = MEM_ADDR_WIDTH'(FB_BASE);
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(FB_BASE + FB_WORDS - 1);
   localparam logic [15:0]               PIX_MASK  = 16'((32'd1 << BPP) - 32'd1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_REQ       = 2'd1;
   localparam logic [1:0] ST_WAIT_CPLT = 2'd2;

   // Reject parameter sets the datapath cannot support.
   if (DATA_WIDTH != 16 || !(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8 || BPP == 16) ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("pixel_fetch_cntrl: illegal DATA_WIDTH/BPP/FIFO_DEPTH");
   end

   logic [1:0]                state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                      discard_q, discard_d;
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [DATA_WIDTH-1:0]     fifo_mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]     word_q, word_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      valid_q, valid_d;
   logic                      underflow_q, underflow_d;
   logic [4:0]                red_q, red_d, blue_q, blue_d;
   logic [5:0]                green_q, green_d;
   logic                      rd_issue, fifo_push, fifo_pop;
   logic [3:0]                shamt;
   logic [15:0]               pix;
   logic [5:0]                grey;

   assign mem.mem_addr    = addr_q;
   assign mem.mem_r_en    = rd_issue;
   assign mem.mem_w_en    = 1'b0;
   assign mem.mem_data_in = '0;

   assign pixel_red   = red_q;
   assign pixel_green = green_q;
   assign pixel_blue  = blue_q;
   assign pixel_valid = valid_q;
   assign underflow   = underflow_q;

   // Fetch FSM: issue one read at a time while FIFO space remains; frame_start
   // rewinds the address and poisons any read still outstanding.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      discard_d = discard_q;
      rd_issue  = 1'b0;
      fifo_push = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && !frame_start && (count_q < FIFO_FULL)) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (frame_start) begin
               state_d = ST_IDLE;
            end else if (mem.mem_rdy) begin
               rd_issue = 1'b1;
               state_d  = ST_WAIT_CPLT;
               addr_d   = (addr_q == ADDR_LAST) ? ADDR_BASE : addr_q + MEM_ADDR_WIDTH'(1);
            end
         end
         ST_WAIT_CPLT: begin
            if (mem.mem_cplt) begin
               state_d   = ST_IDLE;
               discard_d = 1'b0;
               fifo_push = !discard_q && !frame_start;
            end else if (frame_start) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (frame_start) addr_d = ADDR_BASE;
   end

   // Serializer and FIFO bookkeeping; an empty serializer refills on its own.
   always_comb begin
      word_d      = word_q;
      idx_d       = idx_q;
      valid_d     = valid_q;
      underflow_d = underflow_q;
      fifo_pop    = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (frame_start) begin
         valid_d = 1'b0;
         idx_d   = '0;
      end else if (!valid_q) begin
         fifo_pop = (count_q != '0);
         if (pixel_req) underflow_d = 1'b1;
      end else if (pixel_req) begin
         if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
         else if (count_q != '0) fifo_pop = 1'b1;
         else valid_d = 1'b0;
      end
      if (fifo_pop) begin
         word_d  = fifo_mem_q[rd_ptr_q];
         idx_d   = '0;
         valid_d = 1'b1;
      end
      if (frame_start) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      end
   end

   // Colour decode from the next serializer state so outputs are registered.
   always_comb begin
      shamt = 4'(32'(idx_d) * BPP);
      pix   = 16'(word_d >> shamt) & PIX_MASK;
      case (BPP)
         1:       grey = {6{pix[0]}};
         2:       grey = {3{pix[1:0]}};
         4:       grey = {pix[3:0], pix[3:2]};
         8:       grey = pix[7:2];
         default: grey = pix[15:10];
      endcase
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (valid_d) begin
         if (BPP == 16) begin
            red_d   = pix[15:11];
            green_d = pix[10:5];
            blue_d  = pix[4:0];
         end else begin
            red_d   = grey[5:1];
            green_d = grey;
            blue_d  = grey[5:1];
         end
      end
   end

   // Control and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= ADDR_BASE;
         discard_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         word_q      <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         underflow_q <= 1'b0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         discard_q   <= discard_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         word_q      <= word_d;
         idx_q       <= idx_d;
         valid_q     <= valid_d;
         underflow_q <= underflow_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem_q[wr_ptr_q] <= mem.mem_data_out;
   end

endmodule

// File: tb/tb_pixel_fetch_cntrl.sv
// Bench for pixel_fetch_cntrl: a 1-bpp instance and a 16-bpp instance share
// stimulus; each has its own single-outstanding-read memory responder.
module tb_pixel_fetch_cntrl;
   localparam int unsigned FB_BASE  = 46336;
   localparam int unsigned FB_WORDS = 3;
   localparam int unsigned DEPTH    = 4;
   localparam logic [23:0] BASE     = 24'(FB_BASE);
   localparam logic [15:0] WHITE    = {5'd31, 6'd63, 5'd31};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0, frame_start = 1'b0, pixel_req = 1'b0;
   logic        mem_rdy = 1'b1, cplt_hold = 1'b0;
   logic [15:0] mem_val = 16'h0;

   logic [4:0]  red_a, blue_a, red_b, blue_b;
   logic [5:0]  green_a, green_b;
   logic        valid_a, uf_a, valid_b, uf_b;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [23:0] addr_a[$];
   logic [23:0] addr_b[$];
   logic [15:0] exp_q[$];

   pixel_fetch_cntrl_if #(.MEM_ADDR_WIDTH(24), .DATA_WIDTH(16)) ma ();
   pixel_fetch_cntrl_if #(.MEM_ADDR_WIDTH(24), .DATA_WIDTH(16)) mb ();

   pixel_fetch_cntrl #(.MEM_ADDR_WIDTH(24), .DATA_WIDTH(16), .BPP(1), .FIFO_DEPTH(DEPTH),
                       .FB_BASE(FB_BASE), .FB_WORDS(FB_WORDS)) u_dut_a (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start), .pixel_req(pixel_req),
      .pixel_red(red_a), .pixel_green(green_a), .pixel_blue(blue_a),
      .pixel_valid(valid_a), .underflow(uf_a), .mem(ma.master));

   pixel_fetch_cntrl #(.MEM_ADDR_WIDTH(24), .DATA_WIDTH(16), .BPP(16), .FIFO_DEPTH(DEPTH),
                       .FB_BASE(FB_BASE), .FB_WORDS(FB_WORDS)) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start), .pixel_req(pixel_req),
      .pixel_red(red_b), .pixel_green(green_b), .pixel_blue(blue_b),
      .pixel_valid(valid_b), .underflow(uf_b), .mem(mb.master));

   always #5 clk = ~clk;

   // Memory responders: capture mem_val on the read strobe, complete one cycle later unless held.
   logic        pend_a = 1'b0, pend_b = 1'b0;
   logic [15:0] pdata_a = 16'h0, pdata_b = 16'h0;
   always @(posedge clk) begin
      if (ma.mem_r_en) begin
         pend_a <= 1'b1; pdata_a <= mem_val; addr_a.push_back(ma.mem_addr);
      end else if (ma.mem_cplt) pend_a <= 1'b0;
      if (mb.mem_r_en) begin
         pend_b <= 1'b1; pdata_b <= mem_val; addr_b.push_back(mb.mem_addr);
      end else if (mb.mem_cplt) pend_b <= 1'b0;
   end
   assign ma.mem_cplt     = pend_a & ~cplt_hold;
   assign ma.mem_data_out = pdata_a;
   assign ma.mem_rdy      = mem_rdy;
   assign mb.mem_cplt     = pend_b & ~cplt_hold;
   assign mb.mem_data_out = pdata_b;
   assign mb.mem_rdy      = mem_rdy;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_req();
      pixel_req = 1'b1; step(1); pixel_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; frame_start = 1'b0; pixel_req = 1'b0;
      mem_rdy = 1'b1; cplt_hold = 1'b0; mem_val = 16'h0;
      step(3);
      addr_a.delete(); addr_b.delete(); exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input bit sel_b, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if ((sel_b ? valid_b : valid_a) === 1'b1) begin ok = 1'b1; break; end
         step(1);
      end
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1; step(2);
      n_checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_a); else n_pass++;
      n_checks++; if (uf_a !== 1'b0) $display("FAIL reset_underflow: got %b want 0", uf_a); else n_pass++;
      n_checks++; if ({red_a, green_a, blue_a} !== 16'h0) $display("FAIL reset_colour: got %h want 0", {red_a, green_a, blue_a}); else n_pass++;
      n_checks++; if (ma.mem_addr !== BASE) $display("FAIL reset_addr: got %h want %h", ma.mem_addr, BASE); else n_pass++;
      n_checks++; if ({ma.mem_w_en, ma.mem_data_in} !== 17'h0) $display("FAIL write_tied_off: got %b/%h want 0/0", ma.mem_w_en, ma.mem_data_in); else n_pass++;
      rst = 1'b0; step(4);
      n_checks++; if ({ma.mem_r_en, addr_a.size() == 0} !== 2'b01) $display("FAIL idle_no_read: r_en %b reads %0d want 0/0", ma.mem_r_en, addr_a.size()); else n_pass++;
   endtask

   task automatic test_bpp1_stream();
      bit ok;
      logic [15:0] exp_pix;
      do_reset();
      mem_val = 16'h0001; enable = 1'b1;
      for (int w = 0; w < 2; w++)
         for (int p = 0; p < 16; p++) exp_q.push_back((p == 0) ? WHITE : 16'h0);
      wait_valid(1'b0, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL bpp1_first_valid: got %b want 1", ok); else n_pass++;
      while (exp_q.size() > 0) begin
         exp_pix = exp_q.pop_front();
         n_checks++;
         if ({valid_a, red_a, green_a, blue_a} !== {1'b1, exp_pix})
            $display("FAIL bpp1_pixel: got v=%b rgb=%h want v=1 rgb=%h", valid_a, {red_a, green_a, blue_a}, exp_pix);
         else n_pass++;
         pulse_req();
      end
      n_checks++; if (uf_a !== 1'b0) $display("FAIL bpp1_no_underflow: got %b want 0", uf_a); else n_pass++;
   endtask

   task automatic test_fifo_limit();
      logic [23:0] exp_addr;
      do_reset();
      mem_val = 16'h0001; enable = 1'b1;
      step(40);
      // FIFO_DEPTH words queued plus the one already held by the serializer.
      n_checks++; if (addr_a.size() != DEPTH + 1) $display("FAIL fill_reads: got %0d want %0d", addr_a.size(), DEPTH + 1); else n_pass++;
      for (int i = 0; i < addr_a.size(); i++) begin
         exp_addr = BASE + 24'(i % FB_WORDS);
         n_checks++; if (addr_a[i] !== exp_addr) $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr_a[i], exp_addr); else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (ma.mem_r_en !== 1'b0) $display("FAIL full_no_read: got %b want 0", ma.mem_r_en); else n_pass++;
         step(1);
      end
      for (int i = 0; i < 16; i++) pulse_req();
      step(10);
      n_checks++; if (addr_a.size() != DEPTH + 2) $display("FAIL refill_read: got %0d want %0d", addr_a.size(), DEPTH + 2); else n_pass++;
      if (addr_a.size() == DEPTH + 2) begin
         n_checks++; if (addr_a[DEPTH + 1] !== BASE + 24'd2) $display("FAIL refill_addr: got %h want %h", addr_a[DEPTH + 1], BASE + 24'd2); else n_pass++;
      end
   endtask

   task automatic test_frame_start_discard();
      bit ok;
      logic [15:0] exp_pix;
      do_reset();
      mem_val = 16'hFFFF; cplt_hold = 1'b1; enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (addr_a.size() >= 1) begin ok = 1'b1; break; end
         step(1);
      end
      n_checks++; if (ok !== 1'b1) $display("FAIL discard_first_read: got %b want 1", ok); else n_pass++;
      frame_start = 1'b1; mem_val = 16'h0000; step(1);
      frame_start = 1'b0; cplt_hold = 1'b0;
      for (int p = 0; p < 16; p++) exp_q.push_back(16'h0);
      wait_valid(1'b0, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL discard_valid: got %b want 1", ok); else n_pass++;
      n_checks++;
      if (addr_a.size() < 2 || addr_a[1] !== BASE) $display("FAIL discard_restart_addr: reads %0d addr %h want %h", addr_a.size(), (addr_a.size() > 1) ? addr_a[1] : 24'h0, BASE);
      else n_pass++;
      while (exp_q.size() > 0) begin
         exp_pix = exp_q.pop_front();
         n_checks++;
         if ({valid_a, red_a, green_a, blue_a} !== {1'b1, exp_pix})
            $display("FAIL discard_pixel: got v=%b rgb=%h want v=1 rgb=%h", valid_a, {red_a, green_a, blue_a}, exp_pix);
         else n_pass++;
         pulse_req();
      end
   endtask

   task automatic test_underflow();
      bit ok;
      do_reset();
      mem_rdy = 1'b0; enable = 1'b1;
      step(5);
      pulse_req();
      n_checks++; if ({uf_a, valid_a} !== 2'b10) $display("FAIL underflow_set: got uf=%b v=%b want 1/0", uf_a, valid_a); else n_pass++;
      n_checks++; if ({red_a, green_a, blue_a} !== 16'h0) $display("FAIL underflow_colour: got %h want 0", {red_a, green_a, blue_a}); else n_pass++;
      mem_val = 16'h0001; mem_rdy = 1'b1;
      wait_valid(1'b0, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL underflow_recover: got %b want 1", ok); else n_pass++;
      n_checks++; if (uf_a !== 1'b1) $display("FAIL underflow_sticky: got %b want 1", uf_a); else n_pass++;
      n_checks++; if ({red_a, green_a, blue_a} !== WHITE) $display("FAIL underflow_pixel: got %h want %h", {red_a, green_a, blue_a}, WHITE); else n_pass++;
   endtask

   task automatic test_bpp16();
      bit ok;
      logic [15:0] vals[4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h1234};
      logic [15:0] exps[4] = '{{5'd31, 6'd0, 5'd0}, {5'd0, 6'd63, 5'd0}, {5'd0, 6'd0, 5'd31}, {5'd2, 6'd17, 5'd20}};
      for (int t = 0; t < 4; t++) begin
         do_reset();
         mem_val = vals[t]; enable = 1'b1;
         exp_q.push_back(exps[t]); exp_q.push_back(exps[t]); exp_q.push_back(exps[t]);
         wait_valid(1'b1, ok);
         n_checks++; if (ok !== 1'b1) $display("FAIL bpp16_valid[%0d]: got %b want 1", t, ok); else n_pass++;
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({valid_b, red_b, green_b, blue_b} !== {1'b1, exp_q[0]})
               $display("FAIL bpp16_rgb[%0d.%0d]: got v=%b rgb=%h want v=1 rgb=%h", t, k, valid_b, {red_b, green_b, blue_b}, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            if (k == 1) pulse_req(); else step(2);
         end
      end
   endtask

   task automatic test_late_cplt();
      bit ok;
      do_reset();
      mem_val = 16'h0001; cplt_hold = 1'b1; enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (addr_a.size() >= 1) begin ok = 1'b1; break; end
         step(1);
      end
      n_checks++; if (ok !== 1'b1) $display("FAIL late_first_read: got %b want 1", ok); else n_pass++;
      rst = 1'b1; enable = 1'b0; step(1);
      rst = 1'b0; cplt_hold = 1'b0; step(4);
      n_checks++; if (valid_a !== 1'b0) $display("FAIL late_cplt_ignored: got %b want 0", valid_a); else n_pass++;
      n_checks++; if (ma.mem_addr !== BASE) $display("FAIL late_addr: got %h want %h", ma.mem_addr, BASE); else n_pass++;
      enable = 1'b1;
      wait_valid(1'b0, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL late_restart_valid: got %b want 1", ok); else n_pass++;
      n_checks++;
      if (addr_a.size() < 2 || addr_a[1] !== BASE) $display("FAIL late_restart_addr: reads %0d want >=2 at %h", addr_a.size(), BASE);
      else n_pass++;
      n_checks++; if ({red_a, green_a, blue_a} !== WHITE) $display("FAIL late_pixel: got %h want %h", {red_a, green_a, blue_a}, WHITE); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_bpp1_stream();
      test_fifo_limit();
      test_frame_start_discard();
      test_underflow();
      test_bpp16();
      test_late_cplt();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
